// File: rtl/sp1_ram_ctrl.sv
// -----------------------------------------------------------------------------
// sp1_ram_ctrl
//
// Purpose:
//    Two-client access controller placed directly in front of a single-port RAM
//    with one cycle of read latency. Clients A and B issue level-held read or
//    write requests. A round-robin pointer picks a winner when both are
//    eligible, and the winner's fields drive the RAM combinationally. The RAM
//    read data arrives one cycle after a read is issued. It is captured into a
//    response register with a valid/ready handshake and tagged with the
//    originating client. ram_dout is never sampled after write or idle cycles,
//    because the RAM leaves it undefined then.
//
// Parameters:
//    AW          address width (matches the RAM)
//    DW          data width (matches the RAM)
//
// Ports:
//    clk         clock
//    rst         asynchronous, active-low reset
//    a_req/b_req             client request (level-held until ack)
//    a_we/b_we               1 = write, 0 = read
//    a_adrs/b_adrs           client address
//    a_din/b_din             client write data
//    a_ack/b_ack             request accepted this cycle
//    rd_valid/rd_ready       read response handshake
//    rd_src                  response owner (0 = A, 1 = B)
//    rd_data                 read response data
//    ram_cs/ram_we/ram_adrs/ram_din   RAM command
//    ram_dout                RAM read data (valid the cycle after a read)
// -----------------------------------------------------------------------------
module sp1_ram_ctrl #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_adrs,
   input  logic [DW-1:0] a_din,
   output logic          a_ack,

   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_adrs,
   input  logic [DW-1:0] b_din,
   output logic          b_ack,

   output logic          rd_valid,
   output logic          rd_src,
   output logic [DW-1:0] rd_data,
   input  logic          rd_ready,

   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_adrs,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   src_e          ptr_q,      ptr_d;       // who wins when both are eligible
   logic          inflight_q, inflight_d;  // a read was issued last cycle
   logic          pend_q,     pend_d;      // owner of the read in flight
   logic          rd_valid_q, rd_valid_d;
   logic          rd_src_q,   rd_src_d;
   logic [DW-1:0] rd_data_q,  rd_data_d;
   logic [AW-1:0] adrs_q,     adrs_d;      // mirror of last granted address
   logic [DW-1:0] din_q,      din_d;       // mirror of last granted write data

   // ---------------------------------------------------------------------------
   // Arbitration and RAM command
   // ---------------------------------------------------------------------------
   logic          read_ok;
   logic          a_elig;
   logic          b_elig;
   logic          grant;
   src_e          gsel;
   logic          g_we;
   logic [AW-1:0] g_adrs;
   logic [DW-1:0] g_din;
   logic          load;

   always_comb begin
      // A new read may only be issued when its result is guaranteed a free
      // slot: nothing is in flight and the response register is empty or being
      // drained on this edge. Writes never produce a result, so they bypass
      // this gate. That keeps a blocked read from stalling the other client's
      // write.
      read_ok = !inflight_q && (!rd_valid_q || rd_ready);

      // Gating with rst forces ack and cs low for the whole reset period.
      a_elig  = rst && a_req && (a_we || read_ok);
      b_elig  = rst && b_req && (b_we || read_ok);
      grant   = a_elig || b_elig;

      if (a_elig && b_elig) begin
         gsel = ptr_q;
      end else if (b_elig) begin
         gsel = SRC_B;
      end else begin
         gsel = SRC_A;
      end

      if (gsel == SRC_B) begin
         g_we   = b_we;
         g_adrs = b_adrs;
         g_din  = b_din;
      end else begin
         g_we   = a_we;
         g_adrs = a_adrs;
         g_din  = a_din;
      end

      a_ack    = grant && (gsel == SRC_A);
      b_ack    = grant && (gsel == SRC_B);

      // When idle, the address and data buses hold the last granted values,
      // so the RAM inputs do not toggle needlessly.
      ram_cs   = grant;
      ram_we   = grant && g_we;
      ram_adrs = grant ? g_adrs : adrs_q;
      ram_din  = grant ? g_din  : din_q;
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      ptr_d      = ptr_q;
      adrs_d     = adrs_q;
      din_d      = din_q;
      inflight_d = 1'b0;
      pend_d     = pend_q;
      rd_valid_d = rd_valid_q;
      rd_src_d   = rd_src_q;
      rd_data_d  = rd_data_q;

      if (grant) begin
         // Hand priority to the client that lost (or did not compete).
         ptr_d  = (gsel == SRC_A) ? SRC_B : SRC_A;
         adrs_d = g_adrs;
         din_d  = g_din;
         if (!g_we) begin
            inflight_d = 1'b1;
            pend_d     = gsel;
         end
      end

      // ram_dout is meaningful only in the cycle after a read was issued.
      load = inflight_q;

      if (load) begin
         // A load takes priority over a pop on the same edge. read_ok
         // guarantees that any older response is being drained right now.
         rd_valid_d = 1'b1;
         rd_data_d  = ram_dout;
         rd_src_d   = pend_q;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q      <= SRC_A;
         inflight_q <= 1'b0;
         pend_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_src_q   <= 1'b0;
         rd_data_q  <= '0;
         adrs_q     <= '0;
         din_q      <= '0;
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         pend_q     <= pend_d;
         rd_valid_q <= rd_valid_d;
         rd_src_q   <= rd_src_d;
         rd_data_q  <= rd_data_d;
         adrs_q     <= adrs_d;
         din_q      <= din_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_src   = rd_src_q;
   assign rd_data  = rd_data_q;

`ifndef SYNTH
   // A result landing on a held, un-drained response would be lost. The
   // read_ok gate is meant to make that unreachable.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(load && rd_valid_q && !rd_ready))
            else $error("sp1_ram_ctrl: read result overwrote a held response");
      end
   end
`endif

endmodule
